// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
//   state_t       : responder FSM states
//   WORD_WIDTH    : data word width (fixed at 32)
//   ADDR_WIDTH    : byte address width
//   addr_error()  : flags misaligned or out-of-range byte addresses
package mem_pkg;

    localparam int unsigned WORD_WIDTH          = 32;
    localparam int unsigned ADDR_WIDTH          = 32;
    localparam int unsigned WAIT_CNT_WIDTH      = 4;
    localparam int unsigned DEFAULT_DEPTH_LOG2  = 8;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned (low two bits set) or any address bit above the word index set.
    function automatic logic addr_error(input logic [ADDR_WIDTH-1:0] addr,
                                        input int unsigned          depth_log2);
        logic err;
        err = (addr[1:0] != 2'b00);
        for (int unsigned i = 2; i < ADDR_WIDTH; i++) begin
            if ((i >= depth_log2 + 2) && addr[i]) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, byte-enabled write, registered read, no reset.
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write enabled byte lanes, 0 = read into rdata
//   addr  : word index
//   wdata : write data
//   be    : byte enables, bit i covers lane [8i+7:8i]
//   rdata : registered read data, holds until the next read
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WORD_WIDTH,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DEPTH_LOG2-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int unsigned DEPTH = 32'(1) << DEPTH_LOG2;
    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage and read register; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned b = 0; b < LANES; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory that answers one request at a time after a
// programmable number of wait states.
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_write             : 1 = write, 0 = read
//   req_addr              : byte address
//   req_wdata, req_be     : write data and byte enables
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : read data (0 for writes and errors)
//   rsp_err               : misaligned or out-of-range request
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = WORD_WIDTH,
    parameter int unsigned DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

    state_t                    state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                      write_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [BE_WIDTH-1:0]       be_q;

    logic                      accept_c;
    logic                      consume_c;
    logic                      mem_go_c;
    logic                      acc_write_c;
    logic [ADDR_WIDTH-1:0]     acc_addr_c;
    logic [DATA_WIDTH-1:0]     acc_wdata_c;
    logic [BE_WIDTH-1:0]       acc_be_c;
    logic                      acc_err_c;
    logic                      ram_en_c;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    logic                      req_ready_d;
    logic                      rsp_valid_d;
    logic [DATA_WIDTH-1:0]     rsp_rdata_d;
    logic                      rsp_err_d;

    assign accept_c  = req_valid && req_ready && (state_q == IDLE);
    assign consume_c = rsp_valid && rsp_ready;

    // With zero wait states the access happens on the accept edge, before the
    // request latches are loaded, so the live request is used in IDLE.
    assign acc_write_c = (state_q == IDLE) ? req_write : write_q;
    assign acc_addr_c  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata_c = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_be_c    = (state_q == IDLE) ? req_be    : be_q;
    assign acc_err_c   = addr_error(acc_addr_c, DEPTH_LOG2);
    assign ram_en_c    = mem_go_c && !acc_err_c;

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (acc_write_c),
        .addr  (acc_addr_c[DEPTH_LOG2+1:2]),
        .wdata (acc_wdata_c),
        .be    (acc_be_c),
        .rdata (ram_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, wait counter, memory strobe and next output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_go_c    = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d  = RESP;
                        mem_go_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    mem_go_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (consume_c) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The RAM read register settles during the first RESP cycle; the
        // response is captured then and held until consumed.
        if ((state_q == RESP) && !rsp_valid) begin
            rsp_err_d   = addr_error(addr_q, DEPTH_LOG2);
            rsp_rdata_d = (write_q || rsp_err_d) ? '0 : ram_rdata;
        end

        rsp_valid_d = (state_q == RESP) && !consume_c;
        req_ready_d = (state_d == IDLE);
    end

    // Wait counter, request latches and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            if (accept_c) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a 2-wait-state instance and a
// zero-wait-state instance share stimulus; sel0 picks which one is observed.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;
    logic        sel0 = 1'b0;

    logic        ready2, valid2, err2;
    logic [31:0] rdata2;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;

    logic        ready_m, valid_m, err_m;
    logic [31:0] rdata_m;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_lat = 3;

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(ready2), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(valid2), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata2), .rsp_err(err2)
    );

    mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(ready0), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(valid0), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata0), .rsp_err(err0)
    );

    assign ready_m = sel0 ? ready0 : ready2;
    assign valid_m = sel0 ? valid0 : valid2;
    assign err_m   = sel0 ? err0   : err2;
    assign rdata_m = sel0 ? rdata0 : rdata2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(ready_m), 32'd1);
    endtask

    // One request; stall > 0 holds rsp_ready low for that many valid cycles
    // while an intruding write is presented.
    task automatic txn(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err, input int stall);
        int lat = 0;
        @(negedge clk);
        wait_ready(tag);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (valid_m) break;
        end
        check({tag, "_valid"}, 32'(valid_m), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, rdata_m, exp_rdata);
        check({tag, "_err"}, 32'(err_m), 32'(exp_err));
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 32'h0000_0010;
            req_wdata = 32'h0;
            req_be    = 4'hF;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_stall_valid"}, 32'(valid_m), 32'd1);
            check({tag, "_stall_rdata"}, rdata_m, exp_rdata);
            check({tag, "_stall_ready"}, 32'(ready_m), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_valid"}, 32'(valid_m), 32'd0);
        check({tag, "_done_ready"}, 32'(ready_m), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready_low", 32'(ready_m), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready_m), 32'd1);
        check("rst_valid", 32'(valid_m), 32'd0);
        check("rst_rdata", rdata_m, 32'd0);
        check("rst_err", 32'(err_m), 32'd0);

        // Two wait states: accept-to-valid is three edges.
        txn("wr4",      1'b1, 32'h10,  32'hDEADBEEF, 4'hF,    32'h0,        1'b0, 0);
        txn("rd4",      1'b0, 32'h10,  32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 0);
        txn("wr8_init", 1'b1, 32'h20,  32'hAABBCCDD, 4'hF,    32'h0,        1'b0, 0);
        txn("wr8_be",   1'b1, 32'h20,  32'h11223344, 4'b0101, 32'h0,        1'b0, 0);
        txn("rd8",      1'b0, 32'h20,  32'h0,        4'h0,    32'hAA22CC44, 1'b0, 0);
        txn("wr0",      1'b1, 32'h0,   32'h01234567, 4'hF,    32'h0,        1'b0, 0);
        txn("rd_mis",   1'b0, 32'h2,   32'h0,        4'h0,    32'h0,        1'b1, 0);
        txn("wr_oor",   1'b1, 32'h400, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1, 0);
        txn("rd0",      1'b0, 32'h0,   32'h0,        4'h0,    32'h01234567, 1'b0, 0);
        txn("rd8_stall",1'b0, 32'h20,  32'h0,        4'h0,    32'hAA22CC44, 1'b0, 5);
        txn("rd4_again",1'b0, 32'h10,  32'h0,        4'h0,    32'hDEADBEEF, 1'b0, 0);

        // Reset during the wait states of a write to word 3.
        txn("wr3",      1'b1, 32'hC,   32'h33333333, 4'hF,    32'h0,        1'b0, 0);
        @(negedge clk);
        wait_ready("wr3_abort");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'hC;
        req_wdata = 32'hBADBAD00;
        req_be    = 4'hF;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_ready_low", 32'(ready_m), 32'd0);
        check("abort_valid_low", 32'(valid_m), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_rsp", 32'(valid_m), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", 32'(ready_m), 32'd1);
        repeat (4) @(negedge clk);
        check("abort_still_no_rsp", 32'(valid_m), 32'd0);
        txn("rd3",      1'b0, 32'hC,   32'h0,        4'h0,    32'h33333333, 1'b0, 0);

        // Zero wait states, rsp_ready high throughout.
        sel0    = 1'b1;
        exp_lat = 1;
        pulse_reset();
        txn("z_wr5",    1'b1, 32'h14,  32'h55555555, 4'hF,    32'h0,        1'b0, 0);
        txn("z_wr6",    1'b1, 32'h18,  32'h66666666, 4'hF,    32'h0,        1'b0, 0);
        txn("z_rd5",    1'b0, 32'h14,  32'h0,        4'h0,    32'h55555555, 1'b0, 0);
        txn("z_rd6",    1'b0, 32'h18,  32'h0,        4'h0,    32'h66666666, 1'b0, 0);
        txn("z_wr5b",   1'b1, 32'h14,  32'h000000A5, 4'b0001, 32'h0,        1'b0, 0);
        txn("z_rd5b",   1'b0, 32'h14,  32'h0,        4'h0,    32'h555555A5, 1'b0, 0);
        txn("z_oor",    1'b0, 32'h400, 32'h0,        4'h0,    32'h0,        1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
